// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator:
// 640x480@60 defaults, colour-bar table and line/frame total calculation.
package vga_timing_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic int calc_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Bar order: red, green, blue, yellow, magenta, cyan, white, black (12-bit RGB)
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hF00;
            3'd1:    rgb = 12'h0F0;
            3'd2:    rgb = 12'h00F;
            3'd3:    rgb = 12'hFF0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'h0FF;
            3'd6:    rgb = 12'hFFF;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable qualified shift register of D stages, W bits wide, resetting
// every stage to RST_VAL; D = 0 is a plain wire.
module vga_delay_line
    import vga_timing_pkg::*;
#(
    parameter int           W       = 1,
    parameter int           D       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    generate
        if (D == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk_i, rst_i, ce_i};
            assign dout_o   = din_i;
        end else begin : g_pipe
            logic [W-1:0] stage_q [D];

            // Shift one stage per enabled cycle, newest value in stage 0
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < D; i++) stage_q[i] <= RST_VAL;
                end else if (ce_i) begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
                end else begin
                    for (int i = 0; i < D; i++) stage_q[i] <= stage_q[i];
                end
            end

            assign dout_o = stage_q[D-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with event pulses and delayed syncs.
// Define VGA_TESTPAT_EN to add an 8-bar colour test pattern on r/g/b.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int PIPE_DLY = 2,
    parameter int FRAME_W  = 16
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               ce,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               de,
    output logic               hs,
    output logic               vs,
    output logic               de_d,
    output logic               hs_d,
    output logic               vs_d,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
`ifdef VGA_TESTPAT_EN
    output logic [3:0]         r,
    output logic [3:0]         g,
    output logic [3:0]         b,
`endif
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOT = calc_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_total(V_VIS, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);

    initial begin
        if ((H_TOT - 1) >= (1 << CNT_W) || (V_TOT - 1) >= (1 << CNT_W))
            $error("vga_timing_gen: CNT_W=%0d too narrow for %0dx%0d totals", CNT_W, H_TOT, V_TOT);
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
            $error("vga_timing_gen: porch and sync widths must be at least 1");
        if (PIPE_DLY < 0 || PIPE_DLY > 8)
            $error("vga_timing_gen: PIPE_DLY=%0d outside 0..8", PIPE_DLY);
    end

    logic               started_q;
    logic [CNT_W-1:0]   hcount_q, vcount_q, hcount_d, vcount_d;
    logic               de_q, hs_q, vs_q;
    logic               line_start_q, frame_start_q, vblank_start_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               line_wrap_s, frame_wrap_s, vblank_s;
    logic [2:0]         sync_dly_s;

    // Next raster position; the first enabled cycle after reset only starts the raster at (0,0)
    always_comb begin
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        vblank_s     = 1'b0;
        if (ce && started_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d    = '0;
                line_wrap_s = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d     = '0;
                    frame_wrap_s = 1'b1;
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                    vblank_s = (vcount_d == V_VIS_C);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end else begin
            hcount_d = hcount_q;
        end
    end

    // Counters and flags derived from the next position so they line up with hcount/vcount
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            started_q      <= 1'b0;
            hcount_q       <= '0;
            vcount_q       <= '0;
            de_q           <= 1'b0;
            hs_q           <= ~HS_POL;
            vs_q           <= ~VS_POL;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            started_q      <= started_q | ce;
            line_start_q   <= line_wrap_s;
            frame_start_q  <= frame_wrap_s;
            vblank_start_q <= vblank_s;
            if (ce) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                de_q     <= (hcount_d < H_VIS_C) && (vcount_d < V_VIS_C);
                hs_q     <= ((hcount_d >= HS_BEG) && (hcount_d < HS_END)) ? HS_POL : ~HS_POL;
                vs_q     <= ((vcount_d >= VS_BEG) && (vcount_d < VS_END)) ? VS_POL : ~VS_POL;
            end
            if (vblank_s) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    vga_delay_line #(
        .W       (3),
        .D       (PIPE_DLY),
        .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
    ) u_sync_dly (
        .clk_i  (pclk),
        .rst_i  (rst),
        .ce_i   (ce),
        .din_i  ({de_q, hs_q, vs_q}),
        .dout_o (sync_dly_s)
    );

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign de           = de_q;
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign {de_d, hs_d, vs_d} = sync_dly_s;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_cnt    = frame_cnt_q;

`ifdef VGA_TESTPAT_EN
    logic [2:0]  bar_s;
    logic [11:0] rgb_q, rgb_dly_s;

    // Bar index = floor(hcount*8/H_VIS) as a chain of constant compares
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) bar_s = ((int'(hcount_d) * 8) >= (k * H_VIS)) ? 3'(k) : bar_s;
    end

    // Colour for the next pixel, aligned with hcount like de
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rgb_q <= 12'h000;
        end else if (ce) begin
            rgb_q <= bar_rgb(bar_s);
        end else begin
            rgb_q <= rgb_q;
        end
    end

    vga_delay_line #(
        .W       (12),
        .D       (PIPE_DLY),
        .RST_VAL (12'h000)
    ) u_rgb_dly (
        .clk_i  (pclk),
        .rst_i  (rst),
        .ce_i   (ce),
        .din_i  (rgb_q),
        .dout_o (rgb_dly_s)
    );

    assign r = de_d ? rgb_dly_s[11:8] : 4'h0;
    assign g = de_d ? rgb_dly_s[7:4]  : 4'h0;
    assign b = de_d ? rgb_dly_s[3:0]  : 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small geometry instance (ce-gated, PIPE_DLY=3) and a
// default-geometry instance (ce=1, PIPE_DLY=0) checked cycle by cycle.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        bit ph; bit pv; int dly;
    } geo_t;

    typedef struct packed {
        bit started; int h; int v;
        bit de; bit hs; bit vs; bit ls; bit fs; bit vb;
        logic [15:0] fc;
        logic [7:0][2:0] hist;
    } mdl_t;

    localparam geo_t GA = '{hv: 8, hf: 2, hs: 2, hb: 2, vv: 4, vf: 1, vs: 1, vb: 1,
                            ph: 1'b1, pv: 1'b1, dly: 3};
    localparam geo_t GB = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                            ph: 1'b0, pv: 1'b0, dly: 0};

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic ce_a = 1'b0;
    logic ce_b = 1'b1;

    logic [3:0]  a_hcount, a_vcount;
    logic        a_de, a_hs, a_vs, a_de_d, a_hs_d, a_vs_d, a_ls, a_fs, a_vb;
    logic [15:0] a_fc;
    logic [9:0]  b_hcount, b_vcount;
    logic        b_de, b_hs, b_vs, b_de_d, b_hs_d, b_vs_d, b_ls, b_fs, b_vb;
    logic [15:0] b_fc;
`ifdef VGA_TESTPAT_EN
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    mdl_t ma, mb;
    logic [44:0] exp_a[$];
    logic [44:0] exp_b[$];

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .PIPE_DLY(3), .FRAME_W(16)
    ) dut_a (
        .pclk(pclk), .rst(rst), .ce(ce_a),
        .hcount(a_hcount), .vcount(a_vcount),
        .de(a_de), .hs(a_hs), .vs(a_vs),
        .de_d(a_de_d), .hs_d(a_hs_d), .vs_d(a_vs_d),
        .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vb),
`ifdef VGA_TESTPAT_EN
        .r(a_r), .g(a_g), .b(a_b),
`endif
        .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .PIPE_DLY(0)
    ) dut_b (
        .pclk(pclk), .rst(rst), .ce(ce_b),
        .hcount(b_hcount), .vcount(b_vcount),
        .de(b_de), .hs(b_hs), .vs(b_vs),
        .de_d(b_de_d), .hs_d(b_hs_d), .vs_d(b_vs_d),
        .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb),
`ifdef VGA_TESTPAT_EN
        .r(b_r), .g(b_g), .b(b_b),
`endif
        .frame_cnt(b_fc)
    );

    wire [44:0] obs_a = {6'd0, a_hcount, 6'd0, a_vcount, a_de, a_hs, a_vs,
                         a_de_d, a_hs_d, a_vs_d, a_ls, a_fs, a_vb, a_fc};
    wire [44:0] obs_b = {b_hcount, b_vcount, b_de, b_hs, b_vs,
                         b_de_d, b_hs_d, b_vs_d, b_ls, b_fs, b_vb, b_fc};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(geo_t g);
        mdl_t m;
        m    = '0;
        m.hs = !g.ph;
        m.vs = !g.pv;
        for (int i = 0; i < 8; i++) m.hist[i] = {1'b0, !g.ph, !g.pv};
        return m;
    endfunction

    // Behavioural raster model: state after one pclk edge with the given enable
    function automatic mdl_t mdl_step(mdl_t m, geo_t g, bit en);
        int ht, vt;
        ht   = g.hv + g.hf + g.hs + g.hb;
        vt   = g.vv + g.vf + g.vs + g.vb;
        m.ls = 1'b0;
        m.fs = 1'b0;
        m.vb = 1'b0;
        if (en) begin
            m.hist = {m.hist[6:0], {m.de, m.hs, m.vs}};
            if (!m.started) begin
                m.started = 1'b1;
            end else if (m.h == ht - 1) begin
                m.h  = 0;
                m.ls = 1'b1;
                if (m.v == vt - 1) begin
                    m.v  = 0;
                    m.fs = 1'b1;
                end else begin
                    m.v = m.v + 1;
                    if (m.v == g.vv) begin
                        m.vb = 1'b1;
                        m.fc = m.fc + 16'd1;
                    end
                end
            end else begin
                m.h = m.h + 1;
            end
            m.de = (m.h < g.hv) && (m.v < g.vv);
            m.hs = (m.h >= g.hv + g.hf && m.h < g.hv + g.hf + g.hs) ? g.ph : !g.ph;
            m.vs = (m.v >= g.vv + g.vf && m.v < g.vv + g.vf + g.vs) ? g.pv : !g.pv;
        end
        return m;
    endfunction

    function automatic logic [44:0] pack_exp(mdl_t m, geo_t g);
        logic [2:0] dd;
        dd = (g.dly == 0) ? {m.de, m.hs, m.vs} : m.hist[g.dly-1];
        return {10'(m.h), 10'(m.v), m.de, m.hs, m.vs, dd, m.ls, m.fs, m.vb, m.fc};
    endfunction

    // Called at a negedge: drive enable, queue expectations, compare after the edge
    task automatic step(input bit en);
        ce_a = en;
        ma = mdl_step(ma, GA, en);
        exp_a.push_back(pack_exp(ma, GA));
        mb = mdl_step(mb, GB, 1'b1);
        exp_b.push_back(pack_exp(mb, GB));
        @(posedge pclk);
        #1;
        if (exp_a.size() > 0) check_eq("cycA", obs_a, exp_a.pop_front());
        else begin n_err++; $display("FAIL qA: scoreboard empty"); end
        if (exp_b.size() > 0) check_eq("cycB", obs_b, exp_b.pop_front());
        else begin n_err++; $display("FAIL qB: scoreboard empty"); end
        @(negedge pclk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        ma = mdl_reset(GA);
        mb = mdl_reset(GB);
        check_eq("rstA", obs_a, pack_exp(ma, GA));
        check_eq("rstB", obs_b, pack_exp(mb, GB));
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    initial begin
        int hs_hi, hs_bad, vs_hi, de_hi, vb_n, fs_n, last_fs, bhs_lo, bde_hi, ls_n;
        hs_hi = 0; hs_bad = 0; vs_hi = 0; de_hi = 0; vb_n = 0; fs_n = 0;
        last_fs = -1; bhs_lo = 0; bde_hi = 0; ls_n = 0;

        @(negedge pclk);
        apply_reset();

        // Continuous enable: 8 small frames, one full default line
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (i < 196) begin
                if (a_hs) hs_hi++;
                if (a_hs && (a_hcount < 4'd10 || a_hcount > 4'd11)) hs_bad++;
                if (a_vs) vs_hi++;
                if (a_de) de_hi++;
            end
            if (a_vb) begin
                vb_n++;
                check_eq("vbpos", {a_hcount, a_vcount}, {4'd0, 4'd4});
            end
            if (a_fs) begin
                if (last_fs >= 0) check_eq("fsper", i - last_fs, 98);
                last_fs = i;
                fs_n++;
            end
            if (!b_hs) bhs_lo++;
            if (b_de) bde_hi++;
`ifdef VGA_TESTPAT_EN
            if (!b_de_d) check_eq("blank", {b_r, b_g, b_b}, 12'h000);
            else if (b_hcount < 10'd80) check_eq("bar0", {b_r, b_g, b_b}, 12'hF00);
            else if (b_hcount >= 10'd560 && b_hcount < 10'd640) check_eq("bar7", {b_r, b_g, b_b}, 12'h000);
`endif
        end
        check_eq("hsA", hs_hi, 28);
        check_eq("hsAwin", hs_bad, 0);
        check_eq("vsA", vs_hi, 28);
        check_eq("deA", de_hi, 64);
        check_eq("vbA", vb_n, 8);
        check_eq("fsA", fs_n, 8);
        check_eq("hsB", bhs_lo, 96);
        check_eq("deB", bde_hi, 640);

        // Alternating enable: 197 enabled cycles cover two full frames
        apply_reset();
        for (int i = 0; i < 394; i++) begin
            step((i % 2) == 0);
            if (a_ls) ls_n++;
        end
        check_eq("fcnt2", a_fc, 16'd2);
        check_eq("lsA", ls_n, 14);

        // Random enable, then reset in mid-frame and resume
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)));
        apply_reset();
        for (int i = 0; i < 120; i++) step(1'b1);
        check_eq("fcnt1", a_fc, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
